// File: rtl/clk_gen_pkg.sv
// Shared constants and types for the clock pattern generator: FSM states,
// configuration address map and output signal indices.
package clk_gen_pkg;

  localparam int N_SIG = 8;

  localparam int ADDR_PERIOD   = 0;
  localparam int ADDR_NFRAMES  = 1;
  localparam int ADDR_WIN_BASE = 2;

  localparam int PERIOD_RST = 10;

  localparam int SIG_CLK_P     = 0;
  localparam int SIG_CLK_SHORT = 1;
  localparam int SIG_CLK_D     = 2;
  localparam int SIG_CLK_DAC   = 3;
  localparam int SIG_CLK_DAC_P = 4;
  localparam int SIG_CLK_DAC_D = 5;
  localparam int SIG_RST       = 6;
  localparam int SIG_STIM      = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/clk_pattern_gen_if.sv
// Configuration/control bus and generated waveforms of clk_pattern_gen.
interface clk_pattern_gen_if #(
  parameter int CNT_W = 16
);
  logic             cfg_we;
  logic [4:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_data;
  logic             start;
  logic             stop;

  logic             out_clk_p;
  logic             out_clk_short;
  logic             out_clk_d;
  logic             out_clk_dac;
  logic             out_clk_dac_p;
  logic             out_clk_dac_d;
  logic             out_RST;
  logic             out_STIM;
  logic             busy;
  logic             frame_tick;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, stop,
    input  out_clk_p, out_clk_short, out_clk_d, out_clk_dac,
           out_clk_dac_p, out_clk_dac_d, out_RST, out_STIM,
           busy, frame_tick
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, stop,
    output out_clk_p, out_clk_short, out_clk_d, out_clk_dac,
           out_clk_dac_p, out_clk_dac_d, out_RST, out_STIM,
           busy, frame_tick
  );
endinterface

// File: rtl/clk_window_cmp.sv
// Registered window compare: output goes high one cycle after the frame
// counter lies in [rise, fall); an empty or inverted window never fires.
module clk_window_cmp #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in_500MHz,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] i_rise,
  input  logic [CNT_W-1:0] i_fall,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_en,
  output logic             o_out
);
  logic w_in_window;

  assign w_in_window = (i_cnt >= i_rise) && (i_cnt < i_fall);

  always_ff @(posedge clk_in_500MHz or negedge reset_n) begin
    if (!reset_n) begin
      o_out <= 1'b0;
    end else begin
      o_out <= i_en && w_in_window;
    end
  end
endmodule

// File: rtl/clk_pattern_gen.sv
// Frame-based pattern generator: a wrapping frame counter drives eight
// window comparators; config is double-buffered and applied at frame edges.
module clk_pattern_gen #(
  parameter int CNT_W = 16,
  parameter int N_SIG = 8
) (
  input  logic             clk_in_500MHz,
  input  logic             reset_n,
  clk_pattern_gen_if.slave bus
);
  import clk_gen_pkg::*;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_period_sh;
  logic [CNT_W-1:0] r_nframes_sh;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_nframes;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_frames_done;
  logic [CNT_W-1:0] w_period_eff;
  logic [CNT_W-1:0] w_last_cnt;
  logic             w_busy;
  logic             w_tick;
  logic             w_copy;
  logic             w_last_frame;
  logic             w_start_run;
  logic             w_wr_period;
  logic             w_wr_nframes;
  logic [N_SIG-1:0] w_out;

  assign w_period_eff = (r_period < CNT_W'(2)) ? CNT_W'(2) : r_period;
  assign w_last_cnt   = w_period_eff - CNT_W'(1);
  assign w_busy       = (r_state != IDLE);
  assign w_tick       = w_busy && (r_cnt == w_last_cnt);
  // Shadow->active transfer samples the pre-write shadow, so a same-cycle
  // write waits for the next transfer.
  assign w_copy       = !w_busy || w_tick;
  assign w_last_frame = (r_nframes != '0) && ((r_frames_done + CNT_W'(1)) == r_nframes);
  assign w_start_run  = (r_state == IDLE) && bus.start;
  assign w_wr_period  = bus.cfg_we && (bus.cfg_addr == 5'(ADDR_PERIOD));
  assign w_wr_nframes = bus.cfg_we && (bus.cfg_addr == 5'(ADDR_NFRAMES));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) w_state_next = RUN;
      end
      RUN: begin
        if (w_tick && (bus.stop || w_last_frame)) w_state_next = IDLE;
        else if (bus.stop)                        w_state_next = STOP;
      end
      STOP: begin
        if (w_tick) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in_500MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_in_500MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_frames_done <= '0;
    end else begin
      r_cnt <= w_copy ? '0 : r_cnt + CNT_W'(1);
      if (w_start_run) begin
        r_frames_done <= '0;
      end else if (w_tick) begin
        r_frames_done <= r_frames_done + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in_500MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_period_sh  <= CNT_W'(PERIOD_RST);
      r_nframes_sh <= '0;
      r_period     <= CNT_W'(PERIOD_RST);
      r_nframes    <= '0;
    end else begin
      if (w_copy) begin
        r_period  <= r_period_sh;
        r_nframes <= r_nframes_sh;
      end
      if (w_wr_period)  r_period_sh  <= bus.cfg_data;
      if (w_wr_nframes) r_nframes_sh <= bus.cfg_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SIG; gi++) begin : g_sig
      logic [CNT_W-1:0] r_rise_sh;
      logic [CNT_W-1:0] r_fall_sh;
      logic [CNT_W-1:0] r_rise;
      logic [CNT_W-1:0] r_fall;
      logic             w_wr_rise;
      logic             w_wr_fall;

      assign w_wr_rise = bus.cfg_we && (bus.cfg_addr == 5'(ADDR_WIN_BASE + 2*gi));
      assign w_wr_fall = bus.cfg_we && (bus.cfg_addr == 5'(ADDR_WIN_BASE + 2*gi + 1));

      always_ff @(posedge clk_in_500MHz or negedge reset_n) begin
        if (!reset_n) begin
          r_rise_sh <= '0;
          r_fall_sh <= '0;
          r_rise    <= '0;
          r_fall    <= '0;
        end else begin
          if (w_copy) begin
            r_rise <= r_rise_sh;
            r_fall <= r_fall_sh;
          end
          if (w_wr_rise) r_rise_sh <= bus.cfg_data;
          if (w_wr_fall) r_fall_sh <= bus.cfg_data;
        end
      end

      clk_window_cmp #(
        .CNT_W (CNT_W)
      ) u_cmp (
        .clk_in_500MHz (clk_in_500MHz),
        .reset_n       (reset_n),
        .i_rise        (r_rise),
        .i_fall        (r_fall),
        .i_cnt         (r_cnt),
        .i_en          (w_busy),
        .o_out         (w_out[gi])
      );
    end
  endgenerate

  assign bus.out_clk_p     = w_out[SIG_CLK_P];
  assign bus.out_clk_short = w_out[SIG_CLK_SHORT];
  assign bus.out_clk_d     = w_out[SIG_CLK_D];
  assign bus.out_clk_dac   = w_out[SIG_CLK_DAC];
  assign bus.out_clk_dac_p = w_out[SIG_CLK_DAC_P];
  assign bus.out_clk_dac_d = w_out[SIG_CLK_DAC_D];
  assign bus.out_RST       = w_out[SIG_RST];
  assign bus.out_STIM      = w_out[SIG_STIM];
  assign bus.busy          = w_busy;
  assign bus.frame_tick    = w_tick;
endmodule
